// File: rtl/pipe_stage.sv
// Reusable pipeline stage register with valid/ready handshake, optional two-entry skid buffer,
// flush, bubble insertion (ctrl forced to zero when empty) and a saturating stall counter.
module pipe_stage #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CTRL_W = 16,
    parameter int unsigned SKID   = 1,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam logic [CNT_W-1:0] CntMax = '1;

    logic              m_valid_q, m_valid_d;
    logic [DATA_W-1:0] m_data_q, m_data_d;
    logic [CTRL_W-1:0] m_ctrl_q, m_ctrl_d;
    logic              s_valid_q, s_valid_d;
    logic [DATA_W-1:0] s_data_q, s_data_d;
    logic [CTRL_W-1:0] s_ctrl_q, s_ctrl_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic              accept;
    logic              m_free;

    // Skid mode derives in_ready from registers only, cutting the out_ready -> in_ready path.
    assign in_ready = !rst && ((SKID != 0) ? !s_valid_q : (!m_valid_q || out_ready));
    assign accept   = in_valid && in_ready;
    assign m_free   = !m_valid_q || out_ready;

    assign out_valid = m_valid_q;
    assign out_data  = m_data_q;
    assign out_ctrl  = m_valid_q ? m_ctrl_q : '0;
    assign occupancy = {1'b0, m_valid_q} + {1'b0, s_valid_q};
    assign stall_cnt = stall_cnt_q;

    always_comb begin
        m_valid_d   = m_valid_q;
        m_data_d    = m_data_q;
        m_ctrl_d    = m_ctrl_q;
        s_valid_d   = s_valid_q;
        s_data_d    = s_data_q;
        s_ctrl_d    = s_ctrl_q;
        stall_cnt_d = stall_cnt_q;

        if (SKID != 0) begin
            if (m_free) begin
                if (s_valid_q) begin
                    m_valid_d = 1'b1;
                    m_data_d  = s_data_q;
                    m_ctrl_d  = s_ctrl_q;
                    s_valid_d = 1'b0;
                end else if (accept) begin
                    m_valid_d = 1'b1;
                    m_data_d  = in_data;
                    m_ctrl_d  = in_ctrl;
                end else begin
                    m_valid_d = 1'b0;
                end
            end else if (accept) begin
                s_valid_d = 1'b1;
                s_data_d  = in_data;
                s_ctrl_d  = in_ctrl;
            end
        end else begin
            if (accept) begin
                m_valid_d = 1'b1;
                m_data_d  = in_data;
                m_ctrl_d  = in_ctrl;
            end else if (m_valid_q && out_ready) begin
                m_valid_d = 1'b0;
            end
        end

        // Flush wins over every load; held payload registers are left as they were.
        if (flush) begin
            m_valid_d = 1'b0;
            s_valid_d = 1'b0;
            m_data_d  = m_data_q;
            m_ctrl_d  = m_ctrl_q;
            s_data_d  = s_data_q;
            s_ctrl_d  = s_ctrl_q;
        end

        if (m_valid_q && !out_ready && (stall_cnt_q != CntMax)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            m_valid_q   <= 1'b0;
            m_data_q    <= '0;
            m_ctrl_q    <= '0;
            s_valid_q   <= 1'b0;
            s_data_q    <= '0;
            s_ctrl_q    <= '0;
            stall_cnt_q <= '0;
        end else begin
            m_valid_q   <= m_valid_d;
            m_data_q    <= m_data_d;
            m_ctrl_q    <= m_ctrl_d;
            s_valid_q   <= s_valid_d;
            s_data_q    <= s_data_d;
            s_ctrl_q    <= s_ctrl_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_pipe_stage.sv
// Directed bench for pipe_stage: a skid instance, a saturating 4-bit-counter skid instance
// sharing its stimulus, and a single-register instance with its own stimulus.
module tb_pipe_stage;

    logic        clk = 1'b0;
    logic        rst;

    logic        a_in_valid, a_flush, a_out_ready;
    logic [31:0] a_in_data;
    logic [15:0] a_in_ctrl;
    logic        a_in_ready, a_out_valid;
    logic [31:0] a_out_data;
    logic [15:0] a_out_ctrl;
    logic [1:0]  a_occ;
    logic [15:0] a_stall;

    logic        c_in_ready, c_out_valid;
    logic [31:0] c_out_data;
    logic [15:0] c_out_ctrl;
    logic [1:0]  c_occ;
    logic [3:0]  c_stall;

    logic        b_in_valid, b_flush, b_out_ready;
    logic [31:0] b_in_data;
    logic [15:0] b_in_ctrl;
    logic        b_in_ready, b_out_valid;
    logic [31:0] b_out_data;
    logic [15:0] b_out_ctrl;
    logic [1:0]  b_occ;
    logic [15:0] b_stall;

    int n_vec = 0;
    int n_err = 0;

    pipe_stage #(.DATA_W(32), .CTRL_W(16), .SKID(1), .CNT_W(16)) u_dut_a (
        .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_data(a_in_data), .in_ctrl(a_in_ctrl), .flush(a_flush), .out_valid(a_out_valid),
        .out_ready(a_out_ready), .out_data(a_out_data), .out_ctrl(a_out_ctrl),
        .occupancy(a_occ), .stall_cnt(a_stall)
    );

    pipe_stage #(.DATA_W(32), .CTRL_W(16), .SKID(1), .CNT_W(4)) u_dut_c (
        .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(c_in_ready),
        .in_data(a_in_data), .in_ctrl(a_in_ctrl), .flush(a_flush), .out_valid(c_out_valid),
        .out_ready(a_out_ready), .out_data(c_out_data), .out_ctrl(c_out_ctrl),
        .occupancy(c_occ), .stall_cnt(c_stall)
    );

    pipe_stage #(.DATA_W(32), .CTRL_W(16), .SKID(0), .CNT_W(16)) u_dut_b (
        .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_data(b_in_data), .in_ctrl(b_in_ctrl), .flush(b_flush), .out_valid(b_out_valid),
        .out_ready(b_out_ready), .out_data(b_out_data), .out_ctrl(b_out_ctrl),
        .occupancy(b_occ), .stall_cnt(b_stall)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge; inputs set afterwards apply to the following edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic v, input logic [31:0] d, input logic [15:0] c,
                           input logic rdy, input logic fl);
        a_in_valid  = v;
        a_in_data   = d;
        a_in_ctrl   = c;
        a_out_ready = rdy;
        a_flush     = fl;
    endtask

    task automatic drive_b(input logic v, input logic [31:0] d, input logic [15:0] c,
                           input logic rdy, input logic fl);
        b_in_valid  = v;
        b_in_data   = d;
        b_in_ctrl   = c;
        b_out_ready = rdy;
        b_flush     = fl;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with a beat offered: nothing may be taken.
        rst = 1'b1;
        drive_a(1'b1, 32'hDEAD, 16'h00FF, 1'b1, 1'b0);
        drive_b(1'b1, 32'hDEAD, 16'h00FF, 1'b1, 1'b0);
        step();
        step();
        check("rst_in_ready_a", a_in_ready, 0);
        check("rst_in_ready_b", b_in_ready, 0);
        check("rst_out_valid", a_out_valid, 0);
        check("rst_out_ctrl", a_out_ctrl, 0);
        check("rst_out_data", a_out_data, 0);
        check("rst_occ", a_occ, 0);
        check("rst_out_valid_b", b_out_valid, 0);
        rst = 1'b0;
        drive_a(1'b0, 32'h0, 16'h0, 1'b1, 1'b0);
        drive_b(1'b0, 32'h0, 16'h0, 1'b1, 1'b0);
        #1;
        check("post_rst_in_ready_a", a_in_ready, 1);
        check("post_rst_in_ready_b", b_in_ready, 1);

        // Streaming 1..8 at full rate through both modes.
        for (int i = 1; i <= 8; i++) begin
            drive_a(1'b1, i, 16'h0001, 1'b1, 1'b0);
            drive_b(1'b1, i, 16'h0001, 1'b1, 1'b0);
            step();
            check("stream_data_a", a_out_data, i);
            check("stream_valid_a", a_out_valid, 1);
            check("stream_data_b", b_out_data, i);
        end
        check("stream_ctrl_a", a_out_ctrl, 16'h0001);
        drive_a(1'b0, 32'h0, 16'h0, 1'b1, 1'b0);
        drive_b(1'b0, 32'h0, 16'h0, 1'b1, 1'b0);
        step();
        check("drain_valid_a", a_out_valid, 0);
        check("bubble_ctrl_a", a_out_ctrl, 0);
        check("drain_data_hold_a", a_out_data, 8);
        check("stream_stall_a", a_stall, 0);
        check("stream_stall_b", b_stall, 0);

        // Backpressure into the skid entry.
        drive_a(1'b1, 32'd1, 16'h0001, 1'b1, 1'b0);
        step();
        check("bp_beat1", a_out_data, 1);
        drive_a(1'b1, 32'd2, 16'h0001, 1'b1, 1'b0);
        step();
        check("bp_beat2", a_out_data, 2);
        drive_a(1'b1, 32'd3, 16'h0001, 1'b0, 1'b0);
        step();
        check("bp_occ_full", a_occ, 2);
        check("bp_in_ready_low", a_in_ready, 0);
        check("bp_head_held", a_out_data, 2);
        drive_a(1'b1, 32'd4, 16'h0001, 1'b0, 1'b0);
        step();
        check("bp_still_full", a_occ, 2);
        check("bp_head_held2", a_out_data, 2);
        drive_a(1'b1, 32'd4, 16'h0001, 1'b1, 1'b0);
        step();
        check("bp_emit3", a_out_data, 3);
        check("bp_occ_one", a_occ, 1);
        check("bp_in_ready_back", a_in_ready, 1);
        step();
        check("bp_emit4", a_out_data, 4);
        drive_a(1'b0, 32'd0, 16'h0, 1'b1, 1'b0);
        step();
        check("bp_empty", a_out_valid, 0);
        check("bp_stall_cnt", a_stall, 2);

        // Flush with both entries held and a beat offered.
        drive_a(1'b1, 32'hA, 16'h0005, 1'b0, 1'b0);
        step();
        drive_a(1'b1, 32'hB, 16'h0005, 1'b0, 1'b0);
        step();
        check("fl_occ_before", a_occ, 2);
        drive_a(1'b1, 32'hC, 16'h0005, 1'b0, 1'b1);
        step();
        check("fl_out_valid", a_out_valid, 0);
        check("fl_out_ctrl", a_out_ctrl, 0);
        check("fl_occ", a_occ, 0);
        check("fl_stall_kept", a_stall, 4);
        drive_a(1'b1, 32'hD, 16'h0007, 1'b1, 1'b0);
        step();
        check("fl_next_data", a_out_data, 32'hD);
        check("fl_next_ctrl", a_out_ctrl, 16'h0007);
        drive_a(1'b0, 32'h0, 16'h0, 1'b1, 1'b0);
        step();
        check("fl_next_gone", a_out_valid, 0);

        // Single-register mode: combinational ready and simultaneous emit/load.
        drive_b(1'b1, 32'h11, 16'h0002, 1'b0, 1'b0);
        step();
        drive_b(1'b1, 32'h22, 16'h0002, 1'b0, 1'b0);
        #1;
        check("s0_in_ready_stall", b_in_ready, 0);
        step();
        check("s0_head_held", b_out_data, 32'h11);
        check("s0_occ", b_occ, 1);
        b_out_ready = 1'b1;
        #1;
        check("s0_in_ready_comb", b_in_ready, 1);
        step();
        check("s0_load22", b_out_data, 32'h22);
        check("s0_valid22", b_out_valid, 1);
        drive_b(1'b1, 32'h33, 16'h0002, 1'b1, 1'b0);
        step();
        check("s0_load33", b_out_data, 32'h33);
        drive_b(1'b1, 32'h44, 16'h0002, 1'b1, 1'b1);
        step();
        check("s0_flush_valid", b_out_valid, 0);
        check("s0_flush_occ", b_occ, 0);
        drive_b(1'b0, 32'h0, 16'h0, 1'b1, 1'b0);
        step();
        check("s0_flush_no44", b_out_valid, 0);
        check("s0_stall_cnt", b_stall, 1);

        // Saturation of the 4-bit counter (already at 4 from the shared stimulus).
        check("sat_start", c_stall, 4);
        drive_a(1'b1, 32'h55, 16'h0001, 1'b0, 1'b0);
        step();
        for (int i = 0; i < 20; i++) step();
        check("sat_c", c_stall, 15);
        check("sat_a_unsat", a_stall, 24);
        step();
        step();
        check("sat_hold", c_stall, 15);
        rst = 1'b1;
        step();
        check("sat_rst_c", c_stall, 0);
        check("sat_rst_a", a_stall, 0);
        check("sat_rst_occ", a_occ, 0);
        rst = 1'b0;
        drive_a(1'b0, 32'h0, 16'h0, 1'b1, 1'b0);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
